fetch_unit: RTL

Instruction-fetch stage of the CPU. Generates word addresses and read enables for the instruction `bram` and captures its one-cycle-latency `data_out`. Buffers fetched words in a 2-entry queue and presents them to decode over a valid/ready handshake. Handles PC redirects from execute by flushing buffered and in-flight fetches.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_queue.sv | 49 ++++
 rtl/fetch_unit.sv | 77 +++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the front end.
package cpu_pkg;
    localparam int XLEN            = 32;
    localparam int INST_WIDTH      = 32;
    localparam int IMEM_ADDR_WIDTH = 18;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, inst}; flush wins over push.
module fetch_queue
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);
    fetch_entry_t entries [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            entries[0] <= '0;
            entries[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= din;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // The issue logic upstream must never let the queue over- or underflow.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            assert (!(push && !pop && count == 2'd2));
            assert (!(pop && count == 2'd0));
        end
    end

    assign head = entries[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, 1-cycle bram request tracking, 2-deep output queue.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [31:0]           mem_data,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst_data,
    output logic [31:0]           inst_pc
);
    logic [31:0]  pc;
    logic [31:0]  inflight_pc;
    logic         inflight;
    logic         pop;
    logic         issue;
    logic [1:0]   count;
    logic [2:0]   occupancy;
    fetch_entry_t head;
    fetch_entry_t resp;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A redirect squashes the handshake; the consumer discards that head.
    assign pop = inst_valid & inst_ready & ~redirect_valid;

    // Slots committed = buffered + in flight - leaving this cycle; never exceed 2.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = ~reset & ~redirect_valid & (occupancy < 3'd2);

    assign mem_enable  = issue;
    assign mem_address = pc[ADDR_WIDTH+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + 32'd4;
                inflight_pc <= pc;
            end
        end
    end

    assign resp.pc   = inflight_pc;
    assign resp.inst = mem_data;

    fetch_queue u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (resp),
        .count (count),
        .head  (head)
    );

    assign inst_valid = (count != 2'd0);
    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;
endmodule
